hf_reader_seq: RTL and testbench
================================

// Module: hf_reader_seq
// PURPOSE
//  Sequences the HF reader front-end through one exchange: TX (modulate) -> GUARD -> RX window -> IDLE.
//  Drives minor_mode/subcarrier_frequency of the HF reader datapath, so firmware issues one start per exchange.
//  Every mode change lands on a 64-sample correlation frame boundary, so no Q/I pair straddles two modes.
// PARAMETERS
//  FRAME_W   8    width of frame counters (TX length, guard, RX timeout, quiet limit)
//  PHASE_W   6    frame phase counter width (64 samples per correlation frame)
// PORTS
//  ck_1356meg        in   1        13.56 MHz clock; all logic on negedge (matches datapath sampling)
//  rst_n             in   1        asynchronous active-low reset
//  start             in   1        1-cycle pulse; begin exchange (ignored unless IDLE)
//  abort             in   1        level; forces IDLE at next frame boundary
//  cfg_full_mod      in   1        1: TX uses SEND_FULL_MOD, 0: SEND_SHALLOW_MOD
//  cfg_rx_iq         in   1        1: RX uses RECEIVE_IQ, 0: RECEIVE_AMPLITUDE
//  cfg_subcarrier    in   2        subcarrier code, latched on start
//  cfg_tx_frames     in   FRAME_W  TX duration in frames (0 => skip TX)
//  cfg_guard_frames  in   FRAME_W  carrier-on settle frames before RX
//  cfg_rx_timeout    in   FRAME_W  frames allowed in RX without activity
//  cfg_quiet_frames  in   FRAME_W  frames of silence after activity that end RX
//  cfg_jam           in   1        request JAM after TX (only with HF_READER_SEQ_JAM_EN)
//  rx_activity       in   1        level from demod: tag subcarrier present this frame
//  minor_mode        out  4        datapath mode (FPGA_HF_READER_MODE_* codes)
//  subcarrier_frequency out 2      latched cfg_subcarrier
//  frame_strobe      out  1        1-cycle pulse at phase 0 of each frame
//  rx_window         out  1        high while in RX
//  busy              out  1        high whenever state != IDLE
//  done              out  1        1-cycle pulse on return to IDLE
//  timed_out         out  1        sticky: last RX ended by timeout; cleared on start
// BEHAVIOUR
//  Reset: state IDLE, phase 0, minor_mode=RECEIVE_AMPLITUDE, subcarrier_frequency=848 kHz code, all flags 0.
//  Phase counter free-runs mod 64; frame_strobe when phase==0. Transitions commit when phase==63,
//   so new minor_mode is valid from phase 0; frame counters load on entry and decrement per frame.
//  start at any phase: latch cfg_*, clear timed_out, pending flag set; committed at next phase 63 (<=64 clk).
//  IDLE: minor_mode RECEIVE_AMPLITUDE (carrier on). -> TX if cfg_tx_frames!=0, else GUARD.
//  TX: SEND_FULL_MOD/SEND_SHALLOW_MOD for cfg_tx_frames frames -> GUARD (or JAM, see below).
//  GUARD: RX mode, rx_window=0, cfg_guard_frames frames (0 => straight to RX) -> RX.
//  RX: rx_window=1; rx_activity sampled at phase 63.
//   No activity seen yet: timeout counter from cfg_rx_timeout; expiry -> IDLE, timed_out=1.
//   After first activity: quiet counter reloads on each active frame; cfg_quiet_frames silent frames -> IDLE.
//  done pulses in the cycle state becomes IDLE after TX/GUARD/RX/JAM; not after reset.
//  abort wins over every other transition at the same boundary; -> IDLE, done pulses, timed_out unchanged.
//  start while busy ignored; start and abort both pending at one boundary: abort wins, start dropped.
//  Counters saturate at 0; no wrap. cfg_* changes mid-exchange have no effect (latched values used).
//  Reset asserted mid-exchange: immediate IDLE, outputs to reset values, no done.
// CONFIGURATION
//  `HF_READER_SEQ_JAM_EN defined: if latched cfg_jam=1, TX -> JAM (minor_mode SEND_JAM) for
//   cfg_rx_timeout frames -> IDLE with done; GUARD/RX skipped, timed_out not set.
//  Not defined: cfg_jam ignored, JAM state and its encoding absent; TX always -> GUARD.
// STRUCTURE
//  Shared package/define file: FPGA_HF_READER_MODE_* and FPGA_HF_READER_SUBCARRIER_* codes (existing),
//   plus new HF_SEQ_ST_IDLE/TX/GUARD/RX/JAM state encodings (3-bit).
//  One sub-module: hf_seq_frame_timer (phase counter, frame_strobe, boundary flag, loadable down-counter).
// TESTING
//  1) tx=3, guard=2, rx_timeout=4, no activity, start at phase 10 -> TX at next phase 0 for 192 clk,
//     GUARD 128 clk, RX 256 clk, done pulse, timed_out=1; minor_mode changes only at phase 0.
//  2) activity in RX frames 1-2, quiet=2 -> RX ends after frame 4, timed_out=0, done pulse.
//  3) abort asserted at phase 20 of TX frame 2 -> IDLE at next phase 0, done=1, busy=0.
//  4) tx=0, guard=0 -> RX entered on first boundary after start; start pulse while busy -> no effect.
//  5) rst_n low mid-RX -> minor_mode=RECEIVE_AMPLITUDE, busy=0 asynchronously, no done after release.
//  6) JAM_EN build, cfg_jam=1, tx=1, rx_timeout=2 -> SEND_JAM for 128 clk then done; non-JAM build -> GUARD.

Source files
------------

// File: rtl/hf_reader_seq_pkg.sv
// Shared HF reader codes: datapath minor modes, subcarrier codes and sequencer state encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hf_reader_seq_pkg;

    localparam logic [3:0] FPGA_HF_READER_MODE_RECEIVE_IQ        = 4'd0;
    localparam logic [3:0] FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE = 4'd1;
    localparam logic [3:0] FPGA_HF_READER_MODE_RECEIVE_PHASE     = 4'd2;
    localparam logic [3:0] FPGA_HF_READER_MODE_SEND_FULL_MOD     = 4'd3;
    localparam logic [3:0] FPGA_HF_READER_MODE_SEND_SHALLOW_MOD  = 4'd4;
    localparam logic [3:0] FPGA_HF_READER_MODE_SNIFF_IQ          = 4'd5;
    localparam logic [3:0] FPGA_HF_READER_MODE_SNIFF_AMPLITUDE   = 4'd6;
    localparam logic [3:0] FPGA_HF_READER_MODE_SNIFF_PHASE       = 4'd7;
    localparam logic [3:0] FPGA_HF_READER_MODE_SEND_JAM          = 4'd8;

    localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_848_KHZ     = 2'd0;
    localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_424_KHZ     = 2'd1;
    localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_212_KHZ     = 2'd2;
    localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_424_484_KHZ = 2'd3;

    typedef enum logic [2:0] {
        HF_SEQ_ST_IDLE  = 3'd0,
        HF_SEQ_ST_TX    = 3'd1,
        HF_SEQ_ST_GUARD = 3'd2,
        HF_SEQ_ST_RX    = 3'd3
`ifdef HF_READER_SEQ_JAM_EN
        , HF_SEQ_ST_JAM = 3'd4
`endif
    } hf_seq_st_e;

    function automatic logic [3:0] hf_rx_mode(input logic iq);
        return iq ? FPGA_HF_READER_MODE_RECEIVE_IQ : FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE;
    endfunction

endpackage

// File: rtl/hf_reader_seq_if.sv
// Firmware-side control/status bundle of the HF reader sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, abort a level.
interface hf_reader_seq_if #(parameter int FRAME_W = 8);
    logic               start;
    logic               abort;
    logic               cfg_full_mod;
    logic               cfg_rx_iq;
    logic [1:0]         cfg_subcarrier;
    logic [FRAME_W-1:0] cfg_tx_frames;
    logic [FRAME_W-1:0] cfg_guard_frames;
    logic [FRAME_W-1:0] cfg_rx_timeout;
    logic [FRAME_W-1:0] cfg_quiet_frames;
    logic               cfg_jam;
    logic               rx_activity;
    logic [3:0]         minor_mode;
    logic [1:0]         subcarrier_frequency;
    logic               frame_strobe;
    logic               rx_window;
    logic               busy;
    logic               done;
    logic               timed_out;

    modport master (
        output start, abort, cfg_full_mod, cfg_rx_iq, cfg_subcarrier, cfg_tx_frames,
               cfg_guard_frames, cfg_rx_timeout, cfg_quiet_frames, cfg_jam, rx_activity,
        input  minor_mode, subcarrier_frequency, frame_strobe, rx_window, busy, done, timed_out
    );

    modport slave (
        input  start, abort, cfg_full_mod, cfg_rx_iq, cfg_subcarrier, cfg_tx_frames,
               cfg_guard_frames, cfg_rx_timeout, cfg_quiet_frames, cfg_jam, rx_activity,
        output minor_mode, subcarrier_frequency, frame_strobe, rx_window, busy, done, timed_out
    );
endinterface

// File: rtl/hf_seq_frame_timer.sv
// Free-running correlation-frame phase counter with frame strobe, boundary flag and a loadable frame down-counter.
// Latency: strobe registered, high during phase 0; boundary is combinational on the last phase.
// Backpressure: none.
module hf_seq_frame_timer #(
    parameter int FRAME_W = 8,
    parameter int PHASE_W = 6
) (
    input  logic               ck_1356meg,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [FRAME_W-1:0] load_val,
    output logic               boundary,
    output logic               frame_strobe,
    output logic [FRAME_W-1:0] cnt
);
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               strobe_q, strobe_d;
    logic [FRAME_W-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_d  = phase_q + PHASE_W'(1);
        strobe_d = (phase_d == '0);
        cnt_d    = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - FRAME_W'(1);
        end
    end

    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign boundary     = &phase_q;
    assign frame_strobe = strobe_q;
    assign cnt          = cnt_q;
endmodule

// File: rtl/hf_reader_seq.sv
// Sequences one HF reader exchange IDLE -> TX -> GUARD -> RX -> IDLE; optional JAM after TX with HF_READER_SEQ_JAM_EN.
// Latency: start commits at the next frame boundary (<=64 clk); every mode change lands on phase 0.
// Backpressure: start ignored while busy or already pending; abort wins at the boundary.
module hf_reader_seq #(
    parameter int FRAME_W = 8,
    parameter int PHASE_W = 6
) (
    input  logic             ck_1356meg,
    input  logic             rst_n,
    hf_reader_seq_if.slave   bus
);
    import hf_reader_seq_pkg::*;

    hf_seq_st_e         state_q, state_d, post_tx_st;
    logic               pend_q, pend_d, abort_q, abort_d, seen_q, seen_d;
    logic               done_q, done_d, timed_out_q, timed_out_d;
    logic               full_mod_q, full_mod_d, rx_iq_q, rx_iq_d;
    logic [1:0]         sub_q, sub_d;
    logic [FRAME_W-1:0] tx_q, tx_d, guard_q, guard_d, tmo_q, tmo_d, quiet_q, quiet_d;
    logic [FRAME_W-1:0] post_tx_len, ld_val, cnt;
    logic               ld, dec, boundary, cnt_le1;
    logic [3:0]         mode;
`ifdef HF_READER_SEQ_JAM_EN
    logic               jam_q, jam_d;
`else
    logic               unused_cfg_jam;
    assign unused_cfg_jam = bus.cfg_jam;
`endif

    hf_seq_frame_timer #(.FRAME_W(FRAME_W), .PHASE_W(PHASE_W)) u_timer (
        .ck_1356meg   (ck_1356meg),
        .rst_n        (rst_n),
        .load         (ld),
        .dec          (dec),
        .load_val     (ld_val),
        .boundary     (boundary),
        .frame_strobe (bus.frame_strobe),
        .cnt          (cnt)
    );

    assign cnt_le1 = (cnt <= FRAME_W'(1));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        abort_d     = abort_q | bus.abort;
        seen_d      = seen_q;
        timed_out_d = timed_out_q;
        full_mod_d  = full_mod_q;
        rx_iq_d     = rx_iq_q;
        sub_d       = sub_q;
        tx_d        = tx_q;
        guard_d     = guard_q;
        tmo_d       = tmo_q;
        quiet_d     = quiet_q;
`ifdef HF_READER_SEQ_JAM_EN
        jam_d       = jam_q;
`endif
        ld          = 1'b0;
        dec         = 1'b0;
        // A zero guard skips straight to RX, so the "after TX" target is shared by IDLE and TX.
        post_tx_st  = (guard_q != '0) ? HF_SEQ_ST_GUARD : HF_SEQ_ST_RX;
        post_tx_len = (guard_q != '0) ? guard_q : tmo_q;
        ld_val      = post_tx_len;

        if (bus.start && (state_q == HF_SEQ_ST_IDLE) && !pend_q) begin
            pend_d      = 1'b1;
            timed_out_d = 1'b0;
            full_mod_d  = bus.cfg_full_mod;
            rx_iq_d     = bus.cfg_rx_iq;
            sub_d       = bus.cfg_subcarrier;
            tx_d        = bus.cfg_tx_frames;
            guard_d     = bus.cfg_guard_frames;
            tmo_d       = bus.cfg_rx_timeout;
            quiet_d     = bus.cfg_quiet_frames;
`ifdef HF_READER_SEQ_JAM_EN
            jam_d       = bus.cfg_jam;
`endif
        end

        if (boundary) begin
            abort_d = 1'b0;
            if (abort_q || bus.abort) begin
                state_d = HF_SEQ_ST_IDLE;
                pend_d  = 1'b0;
            end else begin
                case (state_q)
                    HF_SEQ_ST_IDLE: if (pend_q) begin
                        pend_d  = 1'b0;
                        ld      = 1'b1;
                        seen_d  = 1'b0;
                        state_d = (tx_q != '0) ? HF_SEQ_ST_TX : post_tx_st;
                        ld_val  = (tx_q != '0) ? tx_q : post_tx_len;
                    end
                    HF_SEQ_ST_TX: if (cnt_le1) begin
                        ld      = 1'b1;
                        seen_d  = 1'b0;
                        state_d = post_tx_st;
`ifdef HF_READER_SEQ_JAM_EN
                        if (jam_q) begin
                            state_d = HF_SEQ_ST_JAM;
                            ld_val  = tmo_q;
                        end
`endif
                    end else begin
                        dec = 1'b1;
                    end
                    HF_SEQ_ST_GUARD: if (cnt_le1) begin
                        ld      = 1'b1;
                        ld_val  = tmo_q;
                        seen_d  = 1'b0;
                        state_d = HF_SEQ_ST_RX;
                    end else begin
                        dec = 1'b1;
                    end
                    // One counter serves both the initial timeout and the post-activity quiet run.
                    HF_SEQ_ST_RX: if (bus.rx_activity) begin
                        seen_d = 1'b1;
                        ld     = 1'b1;
                        ld_val = quiet_q;
                    end else if (cnt_le1) begin
                        state_d = HF_SEQ_ST_IDLE;
                        if (!seen_q) timed_out_d = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
`ifdef HF_READER_SEQ_JAM_EN
                    HF_SEQ_ST_JAM: if (cnt_le1) state_d = HF_SEQ_ST_IDLE;
                                   else dec = 1'b1;
`endif
                    default: state_d = HF_SEQ_ST_IDLE;
                endcase
            end
        end

        done_d = (state_q != HF_SEQ_ST_IDLE) && (state_d == HF_SEQ_ST_IDLE);
    end

    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HF_SEQ_ST_IDLE;
            pend_q      <= 1'b0;
            abort_q     <= 1'b0;
            seen_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            full_mod_q  <= 1'b0;
            rx_iq_q     <= 1'b0;
            sub_q       <= FPGA_HF_READER_SUBCARRIER_848_KHZ;
            tx_q        <= '0;
            guard_q     <= '0;
            tmo_q       <= '0;
            quiet_q     <= '0;
`ifdef HF_READER_SEQ_JAM_EN
            jam_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            abort_q     <= abort_d;
            seen_q      <= seen_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            full_mod_q  <= full_mod_d;
            rx_iq_q     <= rx_iq_d;
            sub_q       <= sub_d;
            tx_q        <= tx_d;
            guard_q     <= guard_d;
            tmo_q       <= tmo_d;
            quiet_q     <= quiet_d;
`ifdef HF_READER_SEQ_JAM_EN
            jam_q       <= jam_d;
`endif
        end
    end

    always_comb begin
        mode = FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE;
        case (state_q)
            HF_SEQ_ST_TX:    mode = full_mod_q ? FPGA_HF_READER_MODE_SEND_FULL_MOD
                                               : FPGA_HF_READER_MODE_SEND_SHALLOW_MOD;
            HF_SEQ_ST_GUARD,
            HF_SEQ_ST_RX:    mode = hf_rx_mode(rx_iq_q);
`ifdef HF_READER_SEQ_JAM_EN
            HF_SEQ_ST_JAM:   mode = FPGA_HF_READER_MODE_SEND_JAM;
`endif
            default:         mode = FPGA_HF_READER_MODE_RECEIVE_AMPLITUDE;
        endcase
    end

    assign bus.minor_mode           = mode;
    assign bus.subcarrier_frequency = sub_q;
    assign bus.rx_window            = (state_q == HF_SEQ_ST_RX);
    assign bus.busy                 = (state_q != HF_SEQ_ST_IDLE);
    assign bus.done                 = done_q;
    assign bus.timed_out            = timed_out_q;
endmodule

// File: tb/tb_hf_reader_seq.sv
// Bench for hf_reader_seq: frame-level reference model compared every cycle, plus directed exchanges
// with hand-computed durations. Build with or without HF_READER_SEQ_JAM_EN.
module tb_hf_reader_seq;
    logic ck = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    hf_reader_seq_if #(.FRAME_W(8)) bus ();

    hf_reader_seq #(.FRAME_W(8), .PHASE_W(6)) dut (
        .ck_1356meg (ck),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: frame-level, counts elapsed frames upward ----------------
    localparam int S_IDLE = 0, S_TX = 1, S_GUARD = 2, S_RX = 3, S_JAM = 4;
    int m_phase, m_st, m_el, m_silent, m_prev;
    int m_tx, m_guard, m_tmo, m_quiet, m_sub;
    bit m_full, m_iq, m_jam, m_pend, m_abort, m_seen, m_done, m_to, m_strobe, m_was_pend;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int m_after_tx();
        return (m_guard != 0) ? S_GUARD : S_RX;
    endfunction

    function automatic logic [3:0] m_mode();
        case (m_st)
            S_TX:          return m_full ? 4'd3 : 4'd4;
            S_GUARD, S_RX: return m_iq ? 4'd0 : 4'd1;
            S_JAM:         return 4'd8;
            default:       return 4'd1;
        endcase
    endfunction

    always @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_st = S_IDLE; m_el = 0; m_silent = 0;
            m_pend = 0; m_abort = 0; m_seen = 0; m_done = 0; m_to = 0; m_strobe = 0;
            m_sub = 0; m_full = 0; m_iq = 0; m_jam = 0;
            m_tx = 0; m_guard = 0; m_tmo = 0; m_quiet = 0;
        end else begin
            m_was_pend = m_pend;
            m_prev = m_st;
            m_done = 0;
            if (bus.start && m_st == S_IDLE && !m_pend) begin
                m_pend = 1; m_to = 0;
                m_full = bus.cfg_full_mod; m_iq = bus.cfg_rx_iq; m_sub = bus.cfg_subcarrier;
                m_tx = bus.cfg_tx_frames; m_guard = bus.cfg_guard_frames;
                m_tmo = bus.cfg_rx_timeout; m_quiet = bus.cfg_quiet_frames; m_jam = bus.cfg_jam;
            end
            if (bus.abort) m_abort = 1;
            if (m_phase == 63) begin
                if (m_abort) begin
                    m_st = S_IDLE; m_pend = 0;
                end else begin
                    m_el++;
                    case (m_st)
                        S_IDLE:  if (m_was_pend) begin
                                     m_pend = 0;
                                     m_st = (m_tx != 0) ? S_TX : m_after_tx();
                                 end
                        S_TX:    if (m_el >= m_tx) begin
                                     m_st = m_after_tx();
`ifdef HF_READER_SEQ_JAM_EN
                                     if (m_jam) m_st = S_JAM;
`endif
                                 end
                        S_GUARD: if (m_el >= m_guard) m_st = S_RX;
                        S_RX:    begin
                                     if (bus.rx_activity) begin m_seen = 1; m_silent = 0; end
                                     else m_silent++;
                                     if (!m_seen && m_el >= max1(m_tmo)) begin m_st = S_IDLE; m_to = 1; end
                                     else if (m_seen && m_silent >= max1(m_quiet)) m_st = S_IDLE;
                                 end
                        S_JAM:   if (m_el >= max1(m_tmo)) m_st = S_IDLE;
                        default: m_st = S_IDLE;
                    endcase
                end
                m_abort = 0;
                if (m_st != m_prev) begin m_el = 0; m_silent = 0; m_seen = 0; end
                if (m_prev != S_IDLE && m_st == S_IDLE) m_done = 1;
            end
            m_phase = (m_phase + 1) % 64;
            m_strobe = (m_phase == 0);
        end
    end

    // Every cycle out of reset: all outputs against the model.
    always @(posedge ck) begin
        logic [10:0] act, exp;
        if (rst_n === 1'b1 && model_en) begin
            act = {bus.minor_mode, bus.subcarrier_frequency, bus.frame_strobe, bus.rx_window,
                   bus.busy, bus.done, bus.timed_out};
            exp = {m_mode(), 2'(m_sub), m_strobe, (m_st == S_RX), (m_st != S_IDLE), m_done, m_to};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_compare t=%0t: got mode/sub/strb/rxw/busy/done/to=%b expected %b",
                         $time, act, exp);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int n_pre, n_tx, n_guard, n_rx, n_jam, n_done, n_bad, n_busy;

    task automatic set_cfg(input int tx, input int guard, input int tmo, input int quiet,
                           input int full, input int iq, input int sub, input int jam);
        bus.cfg_tx_frames = 8'(tx);   bus.cfg_guard_frames = 8'(guard);
        bus.cfg_rx_timeout = 8'(tmo); bus.cfg_quiet_frames = 8'(quiet);
        bus.cfg_full_mod = 1'(full);  bus.cfg_rx_iq = 1'(iq);
        bus.cfg_subcarrier = 2'(sub); bus.cfg_jam = 1'(jam);
    endtask

    // Pulses start during phase 10 of a frame; returns at the phase-11 posedge.
    task automatic start_at_phase10();
        int n = 0;
        @(posedge ck);
        while (!bus.frame_strobe && n < 200) begin @(posedge ck); n++; end
        check("strobe_wait", int'(n < 200), 1);
        repeat (10) @(posedge ck);
        bus.start = 1'b1;
        @(posedge ck);
        bus.start = 1'b0;
    endtask

    // Watches one exchange until done; optionally drives rx activity per RX frame, abort after
    // abort_at TX cycles, and a stray start (with new cfg) after restart_at busy cycles.
    task automatic measure(input int act_mask, input int abort_at, input int restart_at, input int budget);
        int idx = 0;
        bit seen_busy = 0, got = 0;
        logic [3:0] prev;
        n_pre = 0; n_tx = 0; n_guard = 0; n_rx = 0; n_jam = 0; n_done = 0; n_bad = 0; n_busy = 0;
        prev = bus.minor_mode;
        for (int i = 0; i < budget; i++) begin
            if (bus.minor_mode != prev && !bus.frame_strobe) n_bad++;
            prev = bus.minor_mode;
            if (abort_at >= 0 && bus.busy && n_tx == abort_at) bus.abort = 1'b1;
            if (restart_at >= 0 && bus.busy && n_busy == restart_at) begin
                bus.start = 1'b1; bus.cfg_subcarrier = 2'd3; bus.cfg_tx_frames = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) seen_busy = 1; else if (!seen_busy) n_pre++;
            if (bus.busy) n_busy++;
            if (bus.busy && (bus.minor_mode == 4'd3 || bus.minor_mode == 4'd4)) n_tx++;
            if (bus.busy && bus.minor_mode == 4'd8) n_jam++;
            if (bus.busy && !bus.rx_window && (bus.minor_mode == 4'd0 || bus.minor_mode == 4'd1)) n_guard++;
            if (bus.rx_window) n_rx++;
            if (!bus.rx_window) idx = 0; else if (bus.frame_strobe) idx++;
            bus.rx_activity = bus.rx_window && (((act_mask >> idx) & 1) != 0);
            if (bus.done) begin n_done++; got = 1; end
            if (got) break;
            @(posedge ck);
        end
        bus.abort = 1'b0; bus.rx_activity = 1'b0; bus.start = 1'b0;
        check("done_seen", int'(got), 1);
        @(posedge ck);
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    initial begin
        int n, bad;
        bus.start = 0; bus.abort = 0; bus.rx_activity = 0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_mode", bus.minor_mode, 1);
        check("rst_sub", bus.subcarrier_frequency, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rxw", bus.rx_window, 0);
        check("rst_to", bus.timed_out, 0);
        check("rst_strobe", bus.frame_strobe, 0);
        #20 rst_n = 1'b1;
        model_en = 1'b1;

        // 1) 3 TX frames, 2 guard, RX timeout 4, no activity
        set_cfg(3, 2, 4, 2, 1, 0, 2, 0);
        start_at_phase10();
        measure(0, -1, -1, 2000);
        check("t1_latency", n_pre, 53);
        check("t1_tx_clk", n_tx, 192);
        check("t1_guard_clk", n_guard, 128);
        check("t1_rx_clk", n_rx, 256);
        check("t1_done", n_done, 1);
        check("t1_phase0_only", n_bad, 0);
        check("t1_timed_out", bus.timed_out, 1);
        check("t1_sub", bus.subcarrier_frequency, 2);

        // 2) activity in RX frames 1-2, quiet 2, timeout 6
        set_cfg(1, 0, 6, 2, 0, 1, 1, 0);
        start_at_phase10();
        measure(32'h6, -1, -1, 2000);
        check("t2_tx_clk", n_tx, 64);
        check("t2_rx_clk", n_rx, 256);
        check("t2_timed_out", bus.timed_out, 0);
        check("t2_done", n_done, 1);

        // 3) abort at phase 20 of TX frame 2
        set_cfg(3, 2, 4, 2, 1, 0, 0, 0);
        start_at_phase10();
        measure(0, 84, -1, 2000);
        check("t3_tx_clk", n_tx, 128);
        check("t3_rx_clk", n_rx + n_guard, 0);
        check("t3_done", n_done, 1);
        check("t3_busy", bus.busy, 0);
        check("t3_timed_out", bus.timed_out, 0);

        // 4) tx=0, guard=0: RX straight away; stray start while busy
        set_cfg(0, 0, 1, 1, 0, 0, 1, 0);
        start_at_phase10();
        measure(0, -1, 10, 2000);
        check("t4_latency", n_pre, 53);
        check("t4_tx_guard", n_tx + n_guard, 0);
        check("t4_rx_clk", n_rx, 64);
        check("t4_sub_kept", bus.subcarrier_frequency, 1);
        bad = 0;
        repeat (130) begin @(posedge ck); if (bus.busy) bad++; end
        check("t4_no_restart", bad, 0);

        // 5) reset mid-RX
        set_cfg(0, 0, 10, 1, 0, 1, 3, 0);
        start_at_phase10();
        n = 0;
        while (!bus.rx_window && n < 300) begin @(posedge ck); n++; end
        check("t5_rx_wait", int'(n < 300), 1);
        repeat (20) @(posedge ck);
        check("t5_in_rx_mode", bus.minor_mode, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_mode", bus.minor_mode, 1);
        check("t5_async_busy", bus.busy, 0);
        check("t5_async_sub", bus.subcarrier_frequency, 0);
        #5 rst_n = 1'b1;
        bad = 0;
        repeat (200) begin @(posedge ck); if (bus.done || bus.busy) bad++; end
        check("t5_no_done", bad, 0);

        // 6) JAM request after 1 TX frame
        set_cfg(1, 1, 2, 1, 1, 0, 0, 1);
        start_at_phase10();
        measure(0, -1, -1, 2000);
        check("t6_tx_clk", n_tx, 64);
`ifdef HF_READER_SEQ_JAM_EN
        check("t6_jam_clk", n_jam, 128);
        check("t6_guard_rx", n_guard + n_rx, 0);
        check("t6_timed_out", bus.timed_out, 0);
`else
        check("t6_jam_clk", n_jam, 0);
        check("t6_guard_clk", n_guard, 64);
        check("t6_rx_clk", n_rx, 128);
        check("t6_timed_out", bus.timed_out, 1);
`endif

        repeat (3) @(posedge ck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
